// File: rtl/test_core_if.sv
// rtl/test_core_if.sv - stall input and per-stage observation bundle for the pipeline skeleton
interface test_core_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic             stall;
   logic [PC_W-1:0]  pc;
   logic             d_valid;
   logic [PC_W-1:0]  d_pc;
   logic             e_valid;
   logic [PC_W-1:0]  e_pc;
   logic             m_valid;
   logic [PC_W-1:0]  m_pc;
   logic             w_valid;
   logic [PC_W-1:0]  w_pc;
   logic [CNT_W-1:0] retire_count;
   logic [CNT_W-1:0] bubble_count;

   modport master (
      input  stall,
      output pc, d_valid, d_pc, e_valid, e_pc, m_valid, m_pc, w_valid, w_pc,
             retire_count, bubble_count
   );

   modport slave (
      output stall,
      input  pc, d_valid, d_pc, e_valid, e_pc, m_valid, m_pc, w_valid, w_pc,
             retire_count, bubble_count
   );
endinterface

// File: rtl/test_core.sv
// rtl/test_core.sv - five-stage F/D/E/M/W pipeline skeleton with stall and retire/bubble counters
module test_core #(
   parameter int              PC_W     = 32,
   parameter int              PC_STEP  = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              CNT_W    = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   test_core_if.master bus
);
   logic [PC_W-1:0]  pc_q;
   logic             d_valid_q, e_valid_q, m_valid_q, w_valid_q;
   logic [PC_W-1:0]  d_pc_q, e_pc_q, m_pc_q, w_pc_q;
   logic [CNT_W-1:0] retire_q, bubble_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         d_valid_q <= 1'b0;
         d_pc_q    <= '0;
         e_valid_q <= 1'b0;
         e_pc_q    <= '0;
         m_valid_q <= 1'b0;
         m_pc_q    <= '0;
         w_valid_q <= 1'b0;
         w_pc_q    <= '0;
         retire_q  <= '0;
         bubble_q  <= '0;
      end else begin
         // A stall holds F/D in place and pushes an empty slot into E
         if (bus.stall) begin
            e_valid_q <= 1'b0;
            e_pc_q    <= '0;
            bubble_q  <= bubble_q + 1'b1;
         end else begin
            pc_q      <= pc_q + PC_W'(PC_STEP);
            d_valid_q <= 1'b1;
            d_pc_q    <= pc_q;
            e_valid_q <= d_valid_q;
            e_pc_q    <= d_pc_q;
         end
         m_valid_q <= e_valid_q;
         m_pc_q    <= e_pc_q;
         w_valid_q <= m_valid_q;
         w_pc_q    <= m_pc_q;
         if (m_valid_q)
            retire_q <= retire_q + 1'b1;
      end
   end

   assign bus.pc           = pc_q;
   assign bus.d_valid      = d_valid_q;
   assign bus.d_pc         = d_pc_q;
   assign bus.e_valid      = e_valid_q;
   assign bus.e_pc         = e_pc_q;
   assign bus.m_valid      = m_valid_q;
   assign bus.m_pc         = m_pc_q;
   assign bus.w_valid      = w_valid_q;
   assign bus.w_pc         = w_pc_q;
   assign bus.retire_count = retire_q;
   assign bus.bubble_count = bubble_q;
endmodule

// File: tb/tb_test_core.sv
// tb/tb_test_core.sv - self-checking bench for test_core against a slot-list pipeline model
module tb_test_core;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   test_core_if #(.PC_W(32), .CNT_W(32)) bus ();

   test_core #(.PC_W(32), .PC_STEP(4), .RESET_PC(32'd0), .CNT_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: the fetch PC plus a list of in-flight slots, index 0 = D ... 3 = W
   logic [31:0] mdl_pc;
   logic        mdl_v  [4];
   logic [31:0] mdl_p  [4];
   logic [31:0] mdl_ret;
   logic [31:0] mdl_bub;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mdl_pc = 32'd0;
         for (int i = 0; i < 4; i++) begin
            mdl_v[i] = 1'b0;
            mdl_p[i] = 32'd0;
         end
         mdl_ret = 32'd0;
         mdl_bub = 32'd0;
      end else begin
         if (mdl_v[2]) mdl_ret = mdl_ret + 32'd1;
         mdl_v[3] = mdl_v[2]; mdl_p[3] = mdl_p[2];
         mdl_v[2] = mdl_v[1]; mdl_p[2] = mdl_p[1];
         if (bus.stall) begin
            mdl_v[1] = 1'b0; mdl_p[1] = 32'd0;
            mdl_bub  = mdl_bub + 32'd1;
         end else begin
            mdl_v[1] = mdl_v[0]; mdl_p[1] = mdl_p[0];
            mdl_v[0] = 1'b1;     mdl_p[0] = mdl_pc;
            mdl_pc   = mdl_pc + 32'd4;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("cyc_pc",      bus.pc,           mdl_pc);
      chk("cyc_d_valid", 32'(bus.d_valid), 32'(mdl_v[0]));
      chk("cyc_d_pc",    bus.d_pc,         mdl_p[0]);
      chk("cyc_e_valid", 32'(bus.e_valid), 32'(mdl_v[1]));
      chk("cyc_e_pc",    bus.e_pc,         mdl_p[1]);
      chk("cyc_m_valid", 32'(bus.m_valid), 32'(mdl_v[2]));
      chk("cyc_m_pc",    bus.m_pc,         mdl_p[2]);
      chk("cyc_w_valid", 32'(bus.w_valid), 32'(mdl_v[3]));
      chk("cyc_w_pc",    bus.w_pc,         mdl_p[3]);
      chk("cyc_retire",  bus.retire_count, mdl_ret);
      chk("cyc_bubble",  bus.bubble_count, mdl_bub);
   end

   task automatic edge_(input logic s);
      bus.stall = s;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] p0, d0, b0;

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.stall = 1'b0;
      #11;
      chk("rst_pc", bus.pc, 32'd0);
      chk("rst_w_valid", 32'(bus.w_valid), 32'd0);
      chk("rst_retire", bus.retire_count, 32'd0);
      chk("rst_bubble", bus.bubble_count, 32'd0);
      rst_n = 1'b1;

      // Four clean edges fill the pipe
      repeat (4) edge_(1'b0);
      chk("t1_pc", bus.pc, 32'd16);
      chk("t1_d_pc", bus.d_pc, 32'd12);
      chk("t1_e_pc", bus.e_pc, 32'd8);
      chk("t1_m_pc", bus.m_pc, 32'd4);
      chk("t1_w_pc", bus.w_pc, 32'd0);
      chk("t1_w_valid", 32'(bus.w_valid), 32'd1);
      chk("t1_retire", bus.retire_count, 32'd1);

      repeat (3) edge_(1'b0);
      chk("t2_pre_pc", bus.pc, 32'd28);
      chk("t2_pre_w_pc", bus.w_pc, 32'd12);
      edge_(1'b1);
      chk("t2_pc", bus.pc, 32'd28);
      chk("t2_d_pc", bus.d_pc, 32'd24);
      chk("t2_e_valid", 32'(bus.e_valid), 32'd0);
      chk("t2_e_pc", bus.e_pc, 32'd0);
      chk("t2_m_pc", bus.m_pc, 32'd20);
      chk("t2_w_pc", bus.w_pc, 32'd16);
      chk("t2_retire", bus.retire_count, 32'd5);
      chk("t2_bubble", bus.bubble_count, 32'd1);

      edge_(1'b0);
      chk("t3_pc", bus.pc, 32'd32);
      chk("t3_d_pc", bus.d_pc, 32'd28);
      chk("t3_e_pc", bus.e_pc, 32'd24);
      chk("t3_m_valid", 32'(bus.m_valid), 32'd0);
      chk("t3_w_pc", bus.w_pc, 32'd20);
      edge_(1'b0);
      chk("t3_w_valid", 32'(bus.w_valid), 32'd0);
      edge_(1'b0);
      chk("t3_w_pc24", bus.w_pc, 32'd24);
      chk("t3_retire", bus.retire_count, 32'd7);

      // Three-cycle stall: F/D frozen, three bubbles walk down to W
      p0 = bus.pc; d0 = bus.d_pc; b0 = bus.bubble_count;
      for (int i = 0; i < 3; i++) begin
         edge_(1'b1);
         chk("t4_pc_frozen", bus.pc, p0);
         chk("t4_d_frozen", bus.d_pc, d0);
      end
      chk("t4_bubbles", bus.bubble_count - b0, 32'd3);
      chk("t4_w_bubble0", 32'(bus.w_valid), 32'd0);
      edge_(1'b0);
      chk("t4_w_bubble1", 32'(bus.w_valid), 32'd0);
      edge_(1'b0);
      chk("t4_w_bubble2", 32'(bus.w_valid), 32'd0);
      edge_(1'b0);
      chk("t4_w_back", 32'(bus.w_valid), 32'd1);
      chk("t4_w_pc", bus.w_pc, d0);

      // Irregular stall pattern, checked by the per-cycle compare
      for (int i = 0; i < 24; i++) edge_(1'((32'h00D3_9A65 >> i) & 1));

      // Asynchronous reset pulse between edges
      #1 rst_n = 1'b0;
      #1;
      chk("t5_pc", bus.pc, 32'd0);
      chk("t5_d_valid", 32'(bus.d_valid), 32'd0);
      chk("t5_m_pc", bus.m_pc, 32'd0);
      chk("t5_retire", bus.retire_count, 32'd0);
      chk("t5_bubble", bus.bubble_count, 32'd0);
      #1 rst_n = 1'b1;

      edge_(1'b1);
      chk("t6_pc", bus.pc, 32'd0);
      chk("t6_d_valid", 32'(bus.d_valid), 32'd0);
      chk("t6_bubble", bus.bubble_count, 32'd1);
      edge_(1'b0);
      chk("t6_d_valid1", 32'(bus.d_valid), 32'd1);
      chk("t6_d_pc", bus.d_pc, 32'd0);
      chk("t6_pc4", bus.pc, 32'd4);
      repeat (6) edge_(1'b0);
      chk("t6_w_pc", bus.w_pc, 32'd12);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
